updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter N, default 4, counter width in bits; SHALL be legal for 2..32.
REQ-002 Parameter MAX, default 9, terminal (modulus-1) value; SHALL satisfy 1 <= MAX <= 2^N-1, otherwise elaboration SHALL fail.
REQ-003 Parameter SAT, default 0, boundary mode: 0 = wrap, 1 = saturate.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 clr  input  1  synchronous clear of count and ovf.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  N  value to load.
REQ-009 en  input  1  count enable, one step per enabled cycle.
REQ-010 up  input  1  runtime direction: 1 = increment, 0 = decrement.
REQ-011 count  output  N  registered count value, always within 0..MAX.
REQ-012 tc  output  1  registered terminal-count pulse.
REQ-013 ovf  output  1  registered sticky boundary flag.
REQ-014 at_max  output  1  high when count == MAX.
REQ-015 at_min  output  1  high when count == 0.

Function
REQ-016 Per-edge priority SHALL be: rstn low > clr > load > en > hold.
REQ-017 clr high: count SHALL become 0, ovf SHALL become 0, tc SHALL become 0.
REQ-018 load high, clr low: count SHALL become min(load_val, MAX); tc SHALL be 0; ovf SHALL be unchanged.
REQ-019 en high, up high, count < MAX: count SHALL become count+1.
REQ-020 en high, up low, count > 0: count SHALL become count-1.
REQ-021 Wrap mode (SAT=0), en high, up high, count == MAX: count SHALL become 0.
REQ-022 Wrap mode (SAT=0), en high, up low, count == 0: count SHALL become MAX.
REQ-023 Saturate mode (SAT=1), en high, stepping beyond MAX or below 0: count SHALL hold its value.
REQ-024 tc SHALL be high for exactly the one cycle following any enabled step taken at the boundary in the current direction (up at MAX, down at 0), in either mode; it SHALL be low otherwise.
REQ-025 Consecutive enabled boundary steps (for example, saturate mode held at MAX with en=1, up=1) SHALL keep tc high on every following cycle.
REQ-026 ovf SHALL set on the same edge that tc sets, and SHALL remain set until clr or reset.
REQ-027 en low with clr and load low: count SHALL hold and tc SHALL be 0.
REQ-028 Direction changes SHALL take effect on the same edge with no extra latency; up may toggle every cycle.
REQ-029 at_max and at_min SHALL be decoded from the registered count only, with no dependence on inputs.
REQ-030 All arithmetic SHALL be N-bit unsigned; count SHALL never leave 0..MAX, including when MAX < 2^N-1.
REQ-031 Step latency SHALL be one clock: an input sampled at edge k is visible on count after edge k.

Reset
REQ-032 rstn low at a rising edge SHALL set count=0, tc=0 and ovf=0, overriding clr, load and en.
REQ-033 Reset asserted mid-count SHALL take effect on the next edge; counting SHALL resume on the first edge with rstn high.
REQ-034 At reset, at_min SHALL be 1 and at_max SHALL be 0.

Verification
REQ-035 Wrap up (N=4, MAX=9, SAT=0): reset, then en=1, up=1 for 12 cycles -> count 1..9,0,1,2; tc high only the cycle count shows 0; ovf=1 afterwards.
REQ-036 Wrap down (N=4, MAX=9, SAT=0): from count 0, en=1, up=0 for 3 cycles -> count 9,8,7; tc high the cycle count shows 9.
REQ-037 Saturate (N=4, MAX=9, SAT=1): load 8, then en=1, up=1 for 4 cycles -> count 9,9,9,9; tc low, high, high, high; ovf=1; then clr -> count=0, ovf=0.
REQ-038 Load clamp and priority: load=1, load_val=15, en=1 -> count=9 (MAX); same edge with clr=1 -> count=0.
REQ-039 Mid-operation reset: count=5, ovf=1, en=1; rstn=0 for one edge -> count=0, ovf=0, tc=0; rstn=1 -> count=1 next edge.
REQ-040 Direction toggle: from count 4, en=1, up alternating 1,0,1,0 -> count 5,4,5,4; tc stays 0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Modulo-(MAX+1) up/down counter with runtime direction, clamped load, and a
// choice of wrap or saturate at the boundaries; tc pulses on boundary steps, ovf is sticky.
module updown_mod_counter #(
   parameter int unsigned      N   = 4,
   parameter longint unsigned  MAX = 9,
   parameter bit               SAT = 1'b0
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         en,
   input  logic         up,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         ovf,
   output logic         at_max,
   output logic         at_min
);

   localparam longint unsigned LIMIT = (64'd1 << N) - 64'd1;

   generate
      if (N < 2 || N > 32) begin : g_bad_n
         $error("updown_mod_counter: N must be within 2..32");
      end
      if (MAX < 64'd1 || MAX > LIMIT) begin : g_bad_max
         $error("updown_mod_counter: MAX must be within 1..2^N-1");
      end
   endgenerate

   localparam logic [N-1:0] MAX_V = MAX[N-1:0];

   logic [N-1:0] count_q, count_d;
   logic         tc_q, tc_d;
   logic         ovf_q, ovf_d;

   logic at_boundary;
   assign at_boundary = up ? (count_q == MAX_V) : (count_q == '0);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (load) begin
         count_d = (load_val > MAX_V) ? MAX_V : load_val;
      end else if (en) begin
         if (at_boundary) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            if (SAT)     count_d = count_q;
            else if (up) count_d = '0;
            else         count_d = MAX_V;
         end else if (up) begin
            count_d = count_q + N'(1);
         end else begin
            count_d = count_q - N'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
      if (!rstn) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count  = count_q;
   assign tc     = tc_q;
   assign ovf    = ovf_q;
   assign at_max = (count_q == MAX_V);
   assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: a vector table drives a wrap-mode counter (N=4, MAX=9), and
// hand-written sequences cover the saturate-mode instance sharing the same inputs.
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       en = 1'b0;
   logic       up = 1'b0;

   logic [3:0] w_count, s_count;
   logic       w_tc, w_ovf, w_at_max, w_at_min;
   logic       s_tc, s_ovf, s_at_max, s_at_min;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   updown_mod_counter #(.N(4), .MAX(9), .SAT(1'b0)) dut_wrap (
      .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .count(w_count), .tc(w_tc), .ovf(w_ovf),
      .at_max(w_at_max), .at_min(w_at_min)
   );

   updown_mod_counter #(.N(4), .MAX(9), .SAT(1'b1)) dut_sat (
      .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .count(s_count), .tc(s_tc), .ovf(s_ovf),
      .at_max(s_at_max), .at_min(s_at_min)
   );

   typedef struct {
      string      name;
      logic       rstn;
      logic       clr;
      logic       load;
      logic [3:0] lv;
      logic       en;
      logic       up;
      logic [3:0] exp_count;
      logic       exp_tc;
      logic       exp_ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string name, input logic r, input logic c, input logic l,
                      input logic [3:0] lv, input logic e, input logic u,
                      input logic [3:0] ec, input logic et, input logic eo);
      vec_t v;
      v.name = name; v.rstn = r; v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u;
      v.exp_count = ec; v.exp_tc = et; v.exp_ovf = eo;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
   task automatic step(input logic r, input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic u);
      @(negedge clk);
      rstn = r; clr = c; load = l; load_val = lv; en = e; up = u;
      @(posedge clk);
      #1;
   endtask

   task automatic check_sat(input string name, input logic [3:0] ec, input logic et,
                            input logic eo);
      check({name, " count"}, 32'(s_count), 32'(ec));
      check({name, " tc"}, 32'(s_tc), 32'(et));
      check({name, " ovf"}, 32'(s_ovf), 32'(eo));
      check({name, " at_max"}, 32'(s_at_max), 32'(ec == 4'd9));
      check({name, " at_min"}, 32'(s_at_min), 32'(ec == 4'd0));
   endtask

   initial begin
      //   name           rstn clr load lv    en up  count tc ovf
      add("reset",        0, 0, 0, 4'd0,  0, 0, 4'd0, 0, 0);
      add("up1",          1, 0, 0, 4'd0,  1, 1, 4'd1, 0, 0);
      add("up2",          1, 0, 0, 4'd0,  1, 1, 4'd2, 0, 0);
      add("up3",          1, 0, 0, 4'd0,  1, 1, 4'd3, 0, 0);
      add("up4",          1, 0, 0, 4'd0,  1, 1, 4'd4, 0, 0);
      add("up5",          1, 0, 0, 4'd0,  1, 1, 4'd5, 0, 0);
      add("up6",          1, 0, 0, 4'd0,  1, 1, 4'd6, 0, 0);
      add("up7",          1, 0, 0, 4'd0,  1, 1, 4'd7, 0, 0);
      add("up8",          1, 0, 0, 4'd0,  1, 1, 4'd8, 0, 0);
      add("up9",          1, 0, 0, 4'd0,  1, 1, 4'd9, 0, 0);
      add("up_wrap",      1, 0, 0, 4'd0,  1, 1, 4'd0, 1, 1);
      add("up11",         1, 0, 0, 4'd0,  1, 1, 4'd1, 0, 1);
      add("up12",         1, 0, 0, 4'd0,  1, 1, 4'd2, 0, 1);
      add("clr",          1, 1, 0, 4'd0,  0, 0, 4'd0, 0, 0);
      add("dn_wrap",      1, 0, 0, 4'd0,  1, 0, 4'd9, 1, 1);
      add("dn8",          1, 0, 0, 4'd0,  1, 0, 4'd8, 0, 1);
      add("dn7",          1, 0, 0, 4'd0,  1, 0, 4'd7, 0, 1);
      add("hold",         1, 0, 0, 4'd0,  0, 1, 4'd7, 0, 1);
      add("load_clamp",   1, 0, 1, 4'd15, 1, 1, 4'd9, 0, 1);
      add("clr_over_ld",  1, 1, 1, 4'd15, 1, 1, 4'd0, 0, 0);
      add("load_max",     1, 0, 1, 4'd9,  0, 0, 4'd9, 0, 0);
      add("load4",        1, 0, 1, 4'd4,  1, 0, 4'd4, 0, 0);
      add("tog_up",       1, 0, 0, 4'd0,  1, 1, 4'd5, 0, 0);
      add("tog_dn",       1, 0, 0, 4'd0,  1, 0, 4'd4, 0, 0);
      add("tog_up2",      1, 0, 0, 4'd0,  1, 1, 4'd5, 0, 0);
      add("tog_dn2",      1, 0, 0, 4'd0,  1, 0, 4'd4, 0, 0);
      add("ld9",          1, 0, 1, 4'd9,  0, 0, 4'd9, 0, 0);
      add("wrap_set_ovf", 1, 0, 0, 4'd0,  1, 1, 4'd0, 1, 1);
      add("tc_drop",      1, 0, 0, 4'd0,  0, 1, 4'd0, 0, 1);
      add("ld4_keep_ovf", 1, 0, 1, 4'd4,  0, 0, 4'd4, 0, 1);
      add("to5",          1, 0, 0, 4'd0,  1, 1, 4'd5, 0, 1);
      add("rst_mid",      0, 0, 1, 4'd7,  1, 1, 4'd0, 0, 0);
      add("resume",       1, 0, 0, 4'd0,  1, 1, 4'd1, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rstn, tbl[i].clr, tbl[i].load, tbl[i].lv, tbl[i].en, tbl[i].up);
         check({tbl[i].name, " count"}, 32'(w_count), 32'(tbl[i].exp_count));
         check({tbl[i].name, " tc"}, 32'(w_tc), 32'(tbl[i].exp_tc));
         check({tbl[i].name, " ovf"}, 32'(w_ovf), 32'(tbl[i].exp_ovf));
         check({tbl[i].name, " at_max"}, 32'(w_at_max), 32'(tbl[i].exp_count == 4'd9));
         check({tbl[i].name, " at_min"}, 32'(w_at_min), 32'(tbl[i].exp_count == 4'd0));
      end

      // Saturate instance: held at MAX with en=1, up=1 keeps tc high every cycle.
      step(0, 0, 0, 4'd0, 0, 0);   check_sat("sat_reset", 4'd0, 0, 0);
      step(1, 0, 1, 4'd8, 0, 0);   check_sat("sat_load8", 4'd8, 0, 0);
      step(1, 0, 0, 4'd0, 1, 1);   check_sat("sat_up1", 4'd9, 0, 0);
      step(1, 0, 0, 4'd0, 1, 1);   check_sat("sat_up2", 4'd9, 1, 1);
      step(1, 0, 0, 4'd0, 1, 1);   check_sat("sat_up3", 4'd9, 1, 1);
      step(1, 0, 0, 4'd0, 1, 1);   check_sat("sat_up4", 4'd9, 1, 1);
      step(1, 0, 0, 4'd0, 1, 0);   check_sat("sat_dir_dn", 4'd8, 0, 1);
      step(1, 1, 0, 4'd0, 1, 1);   check_sat("sat_clr", 4'd0, 0, 0);
      step(1, 0, 0, 4'd0, 1, 0);   check_sat("sat_dn_floor", 4'd0, 1, 1);
      step(1, 0, 0, 4'd0, 1, 0);   check_sat("sat_dn_floor2", 4'd0, 1, 1);
      step(1, 0, 0, 4'd0, 0, 0);   check_sat("sat_idle", 4'd0, 0, 1);
      step(1, 0, 1, 4'd12, 0, 0);  check_sat("sat_clamp", 4'd9, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
